// File: rtl/stream_in_framer.sv
// rtl/stream_in_framer.sv - AXI4-Stream video line/frame framer with alignment flags
// Optional saturating error counter on port err_cnt: define STREAM_IN_FRAMER_ERR_CNT_EN.
module stream_in_framer #(
  parameter int    DSIZE      = 24,
  parameter string MODE       = "LINE",
  parameter string FRAME_SYNC = "OFF"
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             aclken,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic             fsync,
  input  logic             fifo_almost_full,
  input  logic [DSIZE-1:0] axi_tdata,
  input  logic             axi_tvalid,
  input  logic             axi_tuser,
  input  logic             axi_tlast,
  output logic             axi_tready,
  output logic [DSIZE-1:0] odata,
  output logic             odata_vld,
  output logic             falign,
  output logic             lalign,
  output logic             ealign,
  output logic             line_err,
  output logic             frame_err,
  output logic             busy
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam bit LINE_MODE = (MODE == "LINE");
  localparam bit EXT_SYNC  = (FRAME_SYNC == "ON");

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [15:0]      hcnt_q, hcnt_d;
  logic [15:0]      vcnt_q, vcnt_d;
  logic [15:0]      hact_q, hact_d;
  logic [15:0]      vact_q, vact_d;
  logic             fsync_pend_q, fsync_pend_d;
  logic             lerr_seen_q, lerr_seen_d;
  logic [DSIZE-1:0] odata_q, odata_d;
  logic             odata_vld_q, odata_vld_d;
  logic             falign_q, falign_d;
  logic             lalign_q, lalign_d;
  logic             ealign_q, ealign_d;
  logic             line_err_q, line_err_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  logic        beat;
  logic        sof;
  logic        dims_ok;
  logic        line_end;
  logic [15:0] hact_m1;
  logic [15:0] vact_m1;
  logic [15:0] hcnt_inc;
  logic [15:0] vcnt_inc;

  assign axi_tready = aresetn & ((state_q == IDLE) | ~fifo_almost_full);
  assign beat       = axi_tvalid & axi_tready & aclken;
  assign sof        = beat & (EXT_SYNC ? fsync_pend_q : axi_tuser);
  assign dims_ok    = (hactive != 16'd0) && (vactive != 16'd0);
  assign hact_m1    = hact_q - 16'd1;
  assign vact_m1    = vact_q - 16'd1;
  assign hcnt_inc   = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
  assign vcnt_inc   = (vcnt_q == 16'hFFFF) ? vcnt_q : vcnt_q + 16'd1;
  assign line_end   = LINE_MODE ? axi_tlast : (hcnt_q == hact_m1);

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    hact_d       = hact_q;
    vact_d       = vact_q;
    fsync_pend_d = fsync_pend_q;
    lerr_seen_d  = lerr_seen_q;
    odata_d      = odata_q;
    odata_vld_d  = 1'b0;
    falign_d     = 1'b0;
    lalign_d     = 1'b0;
    ealign_d     = 1'b0;
    line_err_d   = 1'b0;
    frame_err_d  = 1'b0;
    if (aclken) begin
      // A new strobe outranks consuming the old one on the same cycle.
      if (EXT_SYNC) begin
        if (sof)   fsync_pend_d = 1'b0;
        if (fsync) fsync_pend_d = 1'b1;
      end
      if (sof && dims_ok) begin
        hact_d      = hactive;
        vact_d      = vactive;
        hcnt_d      = 16'd1;
        vcnt_d      = 16'd0;
        lerr_seen_d = 1'b0;
        state_d     = ACTIVE;
        odata_d     = axi_tdata;
        odata_vld_d = 1'b1;
        falign_d    = 1'b1;
        frame_err_d = (state_q == ACTIVE);
      end else if (sof && (state_q == ACTIVE)) begin
        // Zero-sized restart: abandon the frame and wait for a usable SOF.
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else if (beat && (state_q == ACTIVE)) begin
        odata_d     = axi_tdata;
        odata_vld_d = 1'b1;
        if (line_end) begin
          lalign_d    = 1'b1;
          hcnt_d      = 16'd0;
          vcnt_d      = vcnt_inc;
          lerr_seen_d = 1'b0;
          line_err_d  = LINE_MODE && (hcnt_q != hact_m1) && !lerr_seen_q;
          if (vcnt_q == vact_m1) begin
            ealign_d = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          hcnt_d = hcnt_inc;
          // Overlong line: flag once when the expected last pixel lacks tlast.
          if (LINE_MODE && (hcnt_q == hact_m1) && !lerr_seen_q) begin
            line_err_d  = 1'b1;
            lerr_seen_d = 1'b1;
          end
        end
      end
    end
    busy_d = (state_d == ACTIVE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      hcnt_q       <= 16'd0;
      vcnt_q       <= 16'd0;
      hact_q       <= 16'd0;
      vact_q       <= 16'd0;
      fsync_pend_q <= 1'b0;
      lerr_seen_q  <= 1'b0;
      odata_q      <= '0;
      odata_vld_q  <= 1'b0;
      falign_q     <= 1'b0;
      lalign_q     <= 1'b0;
      ealign_q     <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hact_q       <= hact_d;
      vact_q       <= vact_d;
      fsync_pend_q <= fsync_pend_d;
      lerr_seen_q  <= lerr_seen_d;
      odata_q      <= odata_d;
      odata_vld_q  <= odata_vld_d;
      falign_q     <= falign_d;
      lalign_q     <= lalign_d;
      ealign_q     <= ealign_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign odata     = odata_q;
  assign odata_vld = odata_vld_q;
  assign falign    = falign_q;
  assign lalign    = lalign_q;
  assign ealign    = ealign_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + {16'd0, line_err_d} + {16'd0, frame_err_d};
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_cnt_q <= 16'd0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_stream_in_framer.sv
// tb/tb_stream_in_framer.sv - directed vector bench for stream_in_framer
// Three instances (LINE/OFF, ONCE/OFF, LINE/ON) share stimulus; each vector checks one.
module tb_stream_in_framer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        aclken = 1'b1;
  logic [15:0] vactive = 16'd0;
  logic [15:0] hactive = 16'd0;
  logic        fsync = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic [23:0] axi_tdata = 24'd0;
  logic        axi_tvalid = 1'b0;
  logic        axi_tuser = 1'b0;
  logic        axi_tlast = 1'b0;

  logic [2:0]  o_rdy, o_vld, o_f, o_l, o_e, o_le, o_fe, o_busy;
  logic [23:0] o_data [3];
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
  logic [15:0] o_ec [3];
  int          ec_exp;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 aclk = ~aclk;

  stream_in_framer #(.DSIZE(24), .MODE("LINE"), .FRAME_SYNC("OFF")) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .vactive(vactive),
    .hactive(hactive), .fsync(fsync), .fifo_almost_full(fifo_almost_full),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tuser(axi_tuser),
    .axi_tlast(axi_tlast), .axi_tready(o_rdy[0]), .odata(o_data[0]),
    .odata_vld(o_vld[0]), .falign(o_f[0]), .lalign(o_l[0]), .ealign(o_e[0]),
    .line_err(o_le[0]), .frame_err(o_fe[0]), .busy(o_busy[0])
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
    , .err_cnt(o_ec[0])
`endif
  );

  stream_in_framer #(.DSIZE(24), .MODE("ONCE"), .FRAME_SYNC("OFF")) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .vactive(vactive),
    .hactive(hactive), .fsync(fsync), .fifo_almost_full(fifo_almost_full),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tuser(axi_tuser),
    .axi_tlast(axi_tlast), .axi_tready(o_rdy[1]), .odata(o_data[1]),
    .odata_vld(o_vld[1]), .falign(o_f[1]), .lalign(o_l[1]), .ealign(o_e[1]),
    .line_err(o_le[1]), .frame_err(o_fe[1]), .busy(o_busy[1])
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
    , .err_cnt(o_ec[1])
`endif
  );

  stream_in_framer #(.DSIZE(24), .MODE("LINE"), .FRAME_SYNC("ON")) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .vactive(vactive),
    .hactive(hactive), .fsync(fsync), .fifo_almost_full(fifo_almost_full),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tuser(axi_tuser),
    .axi_tlast(axi_tlast), .axi_tready(o_rdy[2]), .odata(o_data[2]),
    .odata_vld(o_vld[2]), .falign(o_f[2]), .lalign(o_l[2]), .ealign(o_e[2]),
    .line_err(o_le[2]), .frame_err(o_fe[2]), .busy(o_busy[2])
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
    , .err_cnt(o_ec[2])
`endif
  );

  // stim = {aclken, tvalid, tuser, tlast, fsync, afull}
  // expv = {tready, vld, falign, lalign, ealign, line_err, frame_err, busy}
  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] ha;
    logic [15:0] va;
    logic [5:0]  stim;
    logic [7:0]  expv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] sel, input logic [15:0] ha, input logic [15:0] va,
                              input logic [5:0] stim, input logic [7:0] expv);
    vec_t t;
    t.sel = sel; t.ha = ha; t.va = va; t.stim = stim; t.expv = expv;
    return t;
  endfunction

  task automatic add(input logic [1:0] sel, input logic [15:0] ha, input logic [15:0] va,
                     input logic [5:0] stim, input logic [7:0] expv);
    tbl.push_back(mk(sel, ha, va, stim, expv));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    {aclken, axi_tvalid, axi_tuser, axi_tlast, fsync, fifo_almost_full} = 6'b100000;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset tready dut%0d", s), {31'd0, o_rdy[s]}, 32'd0);
      chk($sformatf("reset outs dut%0d", s),
          {25'd0, o_vld[s], o_f[s], o_l[s], o_e[s], o_le[s], o_fe[s], o_busy[s]}, 32'd0);
      chk($sformatf("reset odata dut%0d", s), {8'd0, o_data[s]}, 32'd0);
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
      chk($sformatf("reset err_cnt dut%0d", s), {16'd0, o_ec[s]}, 32'd0);
`endif
    end
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
    ec_exp = 0;
`endif
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [23:0] d;
    logic [15:0] id16;
    id16 = idx[15:0];
    d = {8'hA5, id16};
    @(negedge aclk);
    {aclken, axi_tvalid, axi_tuser, axi_tlast, fsync, fifo_almost_full} = t.stim;
    hactive   = t.ha;
    vactive   = t.va;
    axi_tdata = d;
    #1;
    chk($sformatf("v%0d tready", idx), {31'd0, o_rdy[t.sel]}, {31'd0, t.expv[7]});
    @(posedge aclk);
    #1;
    chk($sformatf("v%0d flags", idx),
        {25'd0, o_vld[t.sel], o_f[t.sel], o_l[t.sel], o_e[t.sel], o_le[t.sel], o_fe[t.sel], o_busy[t.sel]},
        {25'd0, t.expv[6:0]});
    if (t.expv[6]) chk($sformatf("v%0d odata", idx), {8'd0, o_data[t.sel]}, {8'd0, d});
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
    ec_exp = ec_exp + int'(t.expv[2]) + int'(t.expv[1]);
    chk($sformatf("v%0d err_cnt", idx), {16'd0, o_ec[t.sel]}, ec_exp);
`endif
  endtask

  initial begin
    // Full 4x2 frame with a discarded leading beat and a trailing one.
    add(0, 4, 2, 6'b110000, 8'b10000000);
    add(0, 4, 2, 6'b111000, 8'b11100001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110100, 8'b11010001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110100, 8'b11011000);
    add(0, 4, 2, 6'b110000, 8'b10000000);
    // Short line: tlast on beat 3 of 4, second line completes the frame.
    add(0, 4, 2, 6'b111000, 8'b11100001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110100, 8'b11010101);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110000, 8'b11000001);
    add(0, 4, 2, 6'b110100, 8'b11011000);
    // Back-pressure for 5 cycles, then clock-enable low for 2, then finish.
    add(0, 4, 1, 6'b111000, 8'b11100001);
    add(0, 4, 1, 6'b110000, 8'b11000001);
    for (int k = 0; k < 5; k++) add(0, 4, 1, 6'b110001, 8'b00000001);
    add(0, 4, 1, 6'b010000, 8'b10000001);
    add(0, 4, 1, 6'b010000, 8'b10000001);
    add(0, 4, 1, 6'b110000, 8'b11000001);
    add(0, 4, 1, 6'b110100, 8'b11011000);
    // Overlong line: one error at the missing tlast, none at the late tlast.
    add(0, 2, 1, 6'b111000, 8'b11100001);
    add(0, 2, 1, 6'b110000, 8'b11000101);
    add(0, 2, 1, 6'b110000, 8'b11000001);
    add(0, 2, 1, 6'b110100, 8'b11011000);
    // SOF together with tlast: SOF wins, no lalign.
    add(0, 4, 1, 6'b111100, 8'b11100001);
    add(0, 4, 1, 6'b110000, 8'b11000001);
    add(0, 4, 1, 6'b110000, 8'b11000001);
    add(0, 4, 1, 6'b110100, 8'b11011000);
    // SOF after 5 beats of a 16-pixel line restarts with new dimensions.
    add(0, 16, 2, 6'b111000, 8'b11100001);
    for (int k = 0; k < 4; k++) add(0, 16, 2, 6'b110000, 8'b11000001);
    add(0, 4, 1, 6'b111000, 8'b11100011);
    add(0, 4, 1, 6'b110000, 8'b11000001);
    add(0, 4, 1, 6'b110000, 8'b11000001);
    add(0, 4, 1, 6'b110100, 8'b11011000);
    // Zero dimensions: SOF ignored.
    add(0, 0, 2, 6'b111000, 8'b10000000);
    add(0, 4, 0, 6'b111000, 8'b10000000);
    add(0, 4, 1, 6'b110000, 8'b10000000);
    // ONCE: hactive=3, vactive=1, then a 3x2 frame with an ignored tlast.
    add(1, 3, 1, 6'b110000, 8'b10000000);
    add(1, 3, 1, 6'b111000, 8'b11100001);
    add(1, 3, 1, 6'b110000, 8'b11000001);
    add(1, 3, 1, 6'b110000, 8'b11011000);
    add(1, 3, 1, 6'b110000, 8'b10000000);
    add(1, 3, 2, 6'b111000, 8'b11100001);
    add(1, 3, 2, 6'b110100, 8'b11000001);
    add(1, 3, 2, 6'b110000, 8'b11010001);
    add(1, 3, 2, 6'b110000, 8'b11000001);
    add(1, 3, 2, 6'b110000, 8'b11000001);
    add(1, 3, 2, 6'b110000, 8'b11011000);
    // External sync: tuser ignored, fsync pends across idle cycles.
    add(2, 2, 1, 6'b111000, 8'b10000000);
    add(2, 2, 1, 6'b100010, 8'b10000000);
    add(2, 2, 1, 6'b100000, 8'b10000000);
    add(2, 2, 1, 6'b100000, 8'b10000000);
    add(2, 2, 1, 6'b100000, 8'b10000000);
    add(2, 2, 1, 6'b110000, 8'b11100001);
    add(2, 2, 1, 6'b110100, 8'b11011000);
    add(2, 2, 1, 6'b110000, 8'b10000000);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i].sel != tbl[i-1].sel) do_reset();
      apply(tbl[i], i);
    end

    // Reset in the middle of a frame drops it; output resumes only on a new SOF.
    do_reset();
    apply(mk(0, 4, 2, 6'b111000, 8'b11100001), 1000);
    apply(mk(0, 4, 2, 6'b110000, 8'b11000001), 1001);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("midreset tready", {31'd0, o_rdy[0]}, 32'd0);
    chk("midreset vld/busy", {30'd0, o_vld[0], o_busy[0]}, 32'd0);
`ifdef STREAM_IN_FRAMER_ERR_CNT_EN
    ec_exp = 0;
`endif
    @(negedge aclk);
    aresetn = 1'b1;
    apply(mk(0, 4, 2, 6'b110000, 8'b10000000), 1002);
    apply(mk(0, 4, 2, 6'b110100, 8'b10000000), 1003);
    apply(mk(0, 4, 2, 6'b111000, 8'b11100001), 1004);

    @(negedge aclk);
    {aclken, axi_tvalid, axi_tuser, axi_tlast, fsync, fifo_almost_full} = 6'b100000;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
